// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: row-scan controller for an 8x8 LED matrix.
// Keeps a double-buffered frame: the front bank is displayed and the back bank
// accepts row writes. A blanking gap precedes every row so the previous row's
// columns never bleed into the next one. A requested bank swap is deferred to the
// row7 -> row0 boundary, so a frame is never shown half old and half new.
module led_matrix_scanner #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_wr_valid,
  output logic       o_wr_ready,
  input  logic [2:0] i_wr_row,
  input  logic [7:0] i_wr_data,
  input  logic       i_swap_req,
  output logic       o_swap_ack,
  output logic       o_frame_start,
  output logic [7:0] o_R,
  output logic [7:0] o_C
);

  // One counter serves both phases, so it is sized for the longer of the two.
  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [2:0]       LAST_ROW   = 3'd7;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // Scan state
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_row;

  // Frame storage: two banks of eight column patterns; r_front selects the displayed one
  logic [7:0]       r_bank [0:1][0:7];
  logic             r_front;
  logic             r_pending;

  // Registered outputs
  logic             r_wr_ready;
  logic             r_swap_ack;
  logic             r_frame_start;
  logic [7:0]       r_R;
  logic [7:0]       r_C;

  // Next-state / next-output wires
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_row_nxt;
  logic             w_frame_edge;
  logic             w_swap_edge;
  logic             w_front_nxt;
  logic             w_pending_nxt;
  logic             w_wr_accept;
  logic [7:0]       w_R_nxt;
  logic [7:0]       w_C_nxt;

  assign o_wr_ready    = r_wr_ready;
  assign o_swap_ack    = r_swap_ack;
  assign o_frame_start = r_frame_start;
  assign o_R           = r_R;
  assign o_C           = r_C;

  // A write is taken only while no swap is waiting, so it can never race the bank toggle.
  assign w_wr_accept = i_wr_valid & r_wr_ready;

  // The end of row 7's blanking gap is the frame boundary; a pending swap happens there.
  assign w_frame_edge = (r_state == ST_BLANK) && (r_cnt == BLANK_LAST) && (r_row == LAST_ROW);
  assign w_swap_edge  = w_frame_edge & r_pending;
  assign w_front_nxt  = r_front ^ w_swap_edge;

  // A request arriving on the swap edge itself is kept for the following frame.
  assign w_pending_nxt = i_swap_req | (r_pending & ~w_swap_edge);

  // State register: scan phase, phase counter and current row
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
      r_row   <= LAST_ROW;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_row   <= w_row_nxt;
    end
  end

  // Next-state logic: BLANK for BLANK_CYC cycles then advance row, DRIVE for SCAN_DIV cycles
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_row_nxt   = r_row;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_nxt = ST_DRIVE;
          w_cnt_nxt   = '0;
          w_row_nxt   = r_row + 3'd1;
        end
      end
      ST_DRIVE: begin
        if (r_cnt == DRIVE_LAST) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output logic: drive values for the state being entered, so outputs move with the state
  always_comb begin
    w_R_nxt = 8'h00;
    w_C_nxt = 8'h00;
    if (w_state_nxt == ST_DRIVE) begin
      w_R_nxt = 8'h01 << w_row_nxt;
      // Row 0 after a swap must already show the new front bank.
      w_C_nxt = r_bank[w_front_nxt][w_row_nxt];
    end
  end

  // Output and swap-control registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_R           <= 8'h00;
      r_C           <= 8'h00;
      r_frame_start <= 1'b0;
      r_swap_ack    <= 1'b0;
      r_front       <= 1'b0;
      r_pending     <= 1'b0;
      r_wr_ready    <= 1'b1;
    end else begin
      r_R           <= w_R_nxt;
      r_C           <= w_C_nxt;
      r_frame_start <= w_frame_edge;
      r_swap_ack    <= w_swap_edge;
      r_front       <= w_front_nxt;
      r_pending     <= w_pending_nxt;
      r_wr_ready    <= ~w_pending_nxt;
    end
  end

  // Back-bank row writes; swapping only flips r_front, nothing is copied
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 8; r++) begin
          r_bank[b][r] <= 8'h00;
        end
      end
    end else if (w_wr_accept) begin
      r_bank[~r_front][i_wr_row] <= i_wr_data;
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner with SCAN_DIV=4, BLANK_CYC=2 (row period 6, frame 48).
// The reference model derives the scan position from the number of clock edges since
// reset release and tracks the two banks, the displayed bank and the pending swap.
module tb_led_matrix_scanner;

  localparam int SD  = 4;
  localparam int BC  = 2;
  localparam int RP  = SD + BC;
  localparam int FRM = 8 * RP;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic       swap_req;
  logic       swap_ack;
  logic       frame_start;
  logic [7:0] R;
  logic [7:0] C;

  always #5 clk = ~clk;

  led_matrix_scanner #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_wr_valid   (wr_valid),
    .o_wr_ready   (wr_ready),
    .i_wr_row     (wr_row),
    .i_wr_data    (wr_data),
    .i_swap_req   (swap_req),
    .o_swap_ack   (swap_ack),
    .o_frame_start(frame_start),
    .o_R          (R),
    .o_C          (C)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         k;        // clock edges since reset release
  int         mpos;     // position within the frame, 0 = first drive cycle of row 0
  logic [7:0] mb [0:1][0:7];
  int         mf;       // displayed bank
  bit         mp;       // swap pending
  logic [7:0] e_R, e_C;
  bit         e_fs, e_ack, e_rdy;
  int         ack_cnt;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    mpos = FRM - BC;
    mf = 0;
    mp = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 8; r++)
        mb[b][r] = 8'h00;
    e_R = 8'h00; e_C = 8'h00; e_fs = 1'b0; e_ack = 1'b0; e_rdy = 1'b1;
  endtask

  // Advance the model by one clock edge using the inputs applied at that edge.
  task automatic model_edge();
    logic [7:0] one;
    bit se;
    int row, q;
    one = 8'h01;
    if (wr_valid && !mp) mb[mf ^ 1][wr_row] = wr_data;
    k++;
    mpos = (k + FRM - BC) % FRM;
    row  = mpos / RP;
    q    = mpos % RP;
    se   = (mpos == 0) && mp;
    if (se) mf = mf ^ 1;
    mp    = swap_req || (mp && !se);
    e_R   = (q < SD) ? (one << row) : 8'h00;
    e_C   = (q < SD) ? mb[mf][row] : 8'h00;
    e_fs  = (mpos == 0);
    e_ack = se;
    e_rdy = !mp;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("R", R, e_R);
    chk("C", C, e_C);
    chk("frame_start", frame_start, e_fs);
    chk("swap_ack", swap_ack, e_ack);
    chk("wr_ready", wr_ready, e_rdy);
    if (R == 8'h00) chk("c_dark_when_r_off", C, 8'h00);
    if (swap_ack) ack_cnt++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_R"}, R, 8'h00);
    chk({tag, "_C"}, C, 8'h00);
    chk({tag, "_fs"}, frame_start, 1'b0);
    chk({tag, "_ack"}, swap_ack, 1'b0);
    chk({tag, "_rdy"}, wr_ready, 1'b1);
  endtask

  initial begin
    reset = 1'b0; wr_valid = 1'b0; wr_row = 3'd0; wr_data = 8'h00; swap_req = 1'b0;
    ack_cnt = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    // Idle scan over more than two frames
    repeat (110) step();

    // Diagonal picture into the back bank, then swap
    for (int r = 0; r < 8; r++) begin
      wr_valid = 1'b1; wr_row = 3'(r); wr_data = 8'h01 << r;
      step();
    end
    wr_valid = 1'b0;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    ack_cnt = 0;
    for (int i = 0; i < 2 * FRM && ack_cnt == 0; i++) step();
    chk("diag_swap_seen", 8'(ack_cnt), 8'd1);
    for (int i = 0; i < FRM - 1; i++) begin
      step();
      if (R != 8'h00) chk("diag_c_eq_r", C, R);
    end

    // Write held while a swap is pending: stalls until the ack cycle
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    wr_valid = 1'b1; wr_row = 3'($urandom_range(0, 7)); wr_data = 8'($urandom);
    ack_cnt = 0;
    for (int i = 0; i < 2 * FRM && ack_cnt == 0; i++) step();
    chk("stall_ack_seen", 8'(ack_cnt), 8'd1);
    chk("stall_ready_on_ack", wr_ready, 1'b1);
    step();
    wr_valid = 1'b0;
    repeat (60) step();

    // Two swap requests inside one frame give exactly one swap
    for (int i = 0; i < 2 * FRM && !e_fs; i++) step();
    chk("align_frame", 8'(e_fs), 8'd1);
    ack_cnt = 0;
    swap_req = 1'b1; step(); swap_req = 1'b0;
    repeat (10) step();
    swap_req = 1'b1; step(); swap_req = 1'b0;
    repeat (60) step();
    chk("double_req_one_ack", 8'(ack_cnt), 8'd1);

    // Swap again without new writes: previous picture returns
    swap_req = 1'b1; step(); swap_req = 1'b0;
    repeat (100) step();

    // Random writes and swap requests
    for (int i = 0; i < 500; i++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_row   = 3'($urandom_range(0, 7));
      wr_data  = 8'($urandom);
      swap_req = ($urandom_range(0, 15) == 0);
      step();
    end
    wr_valid = 1'b0; swap_req = 1'b0;

    // Asynchronous reset in the middle of row 3's drive
    for (int i = 0; i < 2 * FRM && mpos != 3 * RP + 1; i++) step();
    chk("row3_reached", R, 8'h08);
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      chk("post_reset_dark", C, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
